fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning instruction ROM address width.
REQ-002 The block SHALL have parameter LUT_DEPTH, default 32, meaning jump-target table entries, indexed by the 5-bit Jptr.
REQ-003 Clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  program launch request; acted on at its rising edge only.
REQ-006 InstrIn  in  9  instruction word from the ROM at the current PC, combinational read.
REQ-007 Done  in  1  halt indication from the decoder.
REQ-008 Jen  in  1  jump-taken indication from the decoder.
REQ-009 Jptr  in  5  jump-table index from the decoder.
REQ-010 LutWe  in  1  jump-table write enable.
REQ-011 LutAddr  in  5  jump-table write index.
REQ-012 LutData  in  PC_W  jump-table write value, an absolute PC.
REQ-013 PC  out  PC_W  ROM read address.
REQ-014 mach_code  out  9  instruction presented to the decoder.
REQ-015 Running  out  1  high while in state RUN.
REQ-016 Halted  out  1  high while in state HALT.
REQ-017 CycleCnt  out  16  count of RUN cycles since the last launch.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and HALT.
REQ-019 Start edge detection: StartEdge = Start AND NOT Start_q, where Start_q is Start registered on Clk.
REQ-020 IDLE or HALT with StartEdge: next state RUN, PC <= 0, CycleCnt <= 0.
REQ-021 In RUN, mach_code SHALL equal InstrIn combinationally, giving zero-cycle fetch latency.
REQ-022 Outside RUN, mach_code SHALL equal NOP 9'b010_000001, so the decoder sees no write and no jump.
REQ-023 RUN next-PC priority:
- Done: state to HALT, PC held;
- else Jen: PC <= LUT[Jptr];
- else PC <= PC+1.
REQ-024 PC+1 SHALL wrap modulo 2^PC_W: from all-ones to 0.
REQ-025 Done and Jen asserted together SHALL take the Done path; the jump is discarded.
REQ-026 CycleCnt SHALL increment once per RUN cycle, including the Done cycle, and saturate at 16'hFFFF.
REQ-027 CycleCnt SHALL hold its value in HALT.
REQ-028 A LUT write SHALL occur on the clock edge when LutWe=1 and the state is IDLE or HALT; LutWe in RUN is ignored.
REQ-029 A LUT write and StartEdge in the same cycle SHALL both take effect; the written entry is visible from the first RUN cycle.
REQ-030 A LUT read SHALL be combinational from the registered table.
REQ-031 Done and Jen SHALL be ignored outside RUN.
REQ-032 StartEdge during RUN SHALL be ignored; there is no restart mid-program.

Reset
REQ-033 Reset=0 SHALL asynchronously force:
- state IDLE;
- PC 0;
- CycleCnt 0;
- Start_q 0;
- all LUT entries 0;
- Running 0, Halted 0, mach_code NOP.
REQ-034 Reset asserted mid-RUN SHALL abort immediately; after release the block waits in IDLE for a new StartEdge.
REQ-035 Start held high through reset release SHALL NOT launch the block; a low-then-high transition is required.

Structure
REQ-036 A shared package SHALL hold:
- the state enum;
- the NOP encoding constant;
- the OP_DONE opcode 3'b010;
- PC_W and LUT_DEPTH defaults.
REQ-037 The jump table SHALL be a separate sub-module jump_lut: 32 x PC_W, one write port, one combinational read port, async clear.
REQ-038 The FSM, PC and CycleCnt SHALL reside in fetch_unit.

Verification
REQ-039 Scenario — launch and step: reset, Start 0->1, InstrIn non-jump -> Running=1; PC 0,1,2,3 on successive edges; CycleCnt 1,2,3.
REQ-040 Scenario — jump: LutAddr=5, LutData=10'h040 in IDLE; launch; Jen=1, Jptr=5 at PC=3 -> next PC=10'h040.
REQ-041 Scenario — Done wins: Done=1 and Jen=1 together at PC=7 -> HALT, PC stays 7, Halted=1, mach_code=9'b010_000001.
REQ-042 Scenario — LUT write blocked in RUN: LutWe=1, LutAddr=2, LutData=10'h0AA during RUN; Jen, Jptr=2 -> PC=prior LUT[2] value (0 after reset).
REQ-043 Scenario — relaunch: in HALT, Start high -> low -> high -> PC=0, CycleCnt=0, RUN; Start held high from HALT entry -> no relaunch.
REQ-044 Scenario — async reset mid-RUN: Reset low with no clock edge -> immediate IDLE, PC 0; PC wraps 10'h3FF -> 10'h000 in a separate run.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Fetch unit shared types and constants.
// Holds the FSM state enum, NOP encoding and sizing defaults.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } state_t;

   localparam logic [2:0] OP_DONE = 3'b010;
   localparam logic [8:0] NOP = {OP_DONE, 6'b000001};

   localparam int PC_W_DEF = 10;
   localparam int LUT_DEPTH_DEF = 32;
   localparam int LUT_AW = 5;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: launch, decoder feedback, LUT load and outputs.
// The slave side is the fetch unit, the master side drives it.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
);

   logic              Start;
   logic [8:0]        InstrIn;
   logic              Done;
   logic              Jen;
   logic [LUT_AW-1:0] Jptr;
   logic              LutWe;
   logic [LUT_AW-1:0] LutAddr;
   logic [PC_W-1:0]   LutData;
   logic [PC_W-1:0]   PC;
   logic [8:0]        mach_code;
   logic              Running;
   logic              Halted;
   logic [15:0]       CycleCnt;

   modport master (
      output Start, InstrIn, Done, Jen, Jptr,
      output LutWe, LutAddr, LutData,
      input  PC, mach_code, Running, Halted, CycleCnt
   );

   modport slave (
      input  Start, InstrIn, Done, Jen, Jptr,
      input  LutWe, LutAddr, LutData,
      output PC, mach_code, Running, Halted, CycleCnt
   );

endinterface

// File: rtl/fetch_unit_jump_lut.sv
// Jump-target table: one write port, combinational read,
// cleared asynchronously on reset.
module jump_lut
   import fetch_unit_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [LUT_AW-1:0] waddr,
   input  logic [PC_W-1:0]   wdata,
   input  logic [LUT_AW-1:0] raddr,
   output logic [PC_W-1:0]   rdata
);

   logic [PC_W-1:0] mem [LUT_DEPTH];

   // Table storage: clear on reset, write when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: launch/run/halt FSM, PC sequencing,
// jump via target table and a saturating RUN cycle counter.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
   input logic         Clk,
   input logic         Reset,
   fetch_unit_if.slave bus
);

   state_t          state;
   logic [PC_W-1:0] pc;
   logic [15:0]     cnt;
   logic            running;
   logic            halted;
   logic            start_q;
   logic            armed;
   logic            start_edge;
   logic            lut_we;
   logic [PC_W-1:0] lut_rd;

   // armed stays low until Start is seen low after reset, so a
   // Start held high through reset release cannot launch.
   assign start_edge = bus.Start & ~start_q & armed;

   // The table is only loadable while no program is running.
   assign lut_we = bus.LutWe & (state != ST_RUN);

   jump_lut #(
      .PC_W      (PC_W),
      .LUT_DEPTH (LUT_DEPTH)
   ) u_lut (
      .clk   (Clk),
      .rst_n (Reset),
      .we    (lut_we),
      .waddr (bus.LutAddr),
      .wdata (bus.LutData),
      .raddr (bus.Jptr),
      .rdata (lut_rd)
   );

   // Start edge tracking, FSM, PC and cycle counter.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         start_q <= 1'b0;
         armed   <= 1'b0;
         state   <= ST_IDLE;
         pc      <= '0;
         cnt     <= '0;
         running <= 1'b0;
         halted  <= 1'b0;
      end else begin
         start_q <= bus.Start;
         armed   <= armed | ~bus.Start;
         unique case (state)
            ST_RUN: begin
               if (cnt != 16'hFFFF) begin
                  cnt <= cnt + 16'd1;
               end
               if (bus.Done) begin
                  state   <= ST_HALT;
                  running <= 1'b0;
                  halted  <= 1'b1;
               end else if (bus.Jen) begin
                  pc <= lut_rd;
               end else begin
                  pc <= pc + 1'b1;
               end
            end
            default: begin
               if (start_edge) begin
                  state   <= ST_RUN;
                  pc      <= '0;
                  cnt     <= '0;
                  running <= 1'b1;
                  halted  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.PC        = pc;
   assign bus.CycleCnt  = cnt;
   assign bus.Running   = running;
   assign bus.Halted    = halted;
   assign bus.mach_code = running ? bus.InstrIn : NOP;

endmodule
